// File: rtl/banzai_pwr_cfg_responder.sv
// banzai_pwr_cfg_responder: AXI-Lite power-state window; holds each component's request until it acks
module banzai_pwr_cfg_responder #(
  parameter int                      ADDR_WIDTH  = 32,
  parameter int                      DATA_WIDTH  = 32,
  parameter int                      NO_COMPS    = 8,
  parameter int                      STATE_WIDTH = 4,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR   = '0,
  parameter logic [STATE_WIDTH-1:0]  RST_STATE   = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_WIDTH-1:0]           aw_addr,
  input  logic                            aw_valid,
  output logic                            aw_ready,
  input  logic [DATA_WIDTH-1:0]           w_data,
  input  logic [3:0]                      w_strb,
  input  logic                            w_valid,
  output logic                            w_ready,
  output logic [1:0]                      b_resp,
  output logic                            b_valid,
  input  logic                            b_ready,
  input  logic [ADDR_WIDTH-1:0]           ar_addr,
  input  logic                            ar_valid,
  output logic                            ar_ready,
  output logic [DATA_WIDTH-1:0]           r_data,
  output logic [1:0]                      r_resp,
  output logic                            r_valid,
  input  logic                            r_ready,
  output logic [NO_COMPS*STATE_WIDTH-1:0] pwr_state_o,
  output logic [NO_COMPS-1:0]             pwr_req_o,
  input  logic [NO_COMPS-1:0]             pwr_ack_i
);
  localparam int CW = NO_COMPS > 1 ? $clog2(NO_COMPS) : 1;
  logic [STATE_WIDTH-1:0] r_state [NO_COMPS];
  logic [NO_COMPS-1:0]    r_busy;
  logic                   r_aw_held, r_w_held, r_w_strb0;
  logic [ADDR_WIDTH-1:0]  r_aw_addr;
  logic [STATE_WIDTH-1:0] r_w_state;
  logic [ADDR_WIDTH-1:0]  w_aw_off, w_ar_off;
  logic [CW-1:0]          w_aw_i, w_ar_i;
  logic                   w_aw_comp, w_ar_comp, w_ar_map, w_exec, w_wr_ok, w_upd, w_unused;
  logic [DATA_WIDTH-1:0]  w_rd_data;
  assign w_aw_off  = r_aw_addr - BASE_ADDR;
  assign w_ar_off  = ar_addr - BASE_ADDR;
  assign w_aw_i    = w_aw_off[CW+1:2];
  assign w_ar_i    = w_ar_off[CW+1:2];
  assign w_aw_comp = w_aw_off[ADDR_WIDTH-1:2] < (ADDR_WIDTH-2)'(NO_COMPS);
  assign w_ar_comp = w_ar_off[ADDR_WIDTH-1:2] < (ADDR_WIDTH-2)'(NO_COMPS);
  assign w_ar_map  = w_ar_off[ADDR_WIDTH-1:2] == (ADDR_WIDTH-2)'(NO_COMPS);
  assign w_exec    = r_aw_held && r_w_held && !b_valid;
  // a component with an outstanding request refuses new writes until acked
  assign w_wr_ok   = w_aw_comp && !r_busy[w_aw_i];
  assign w_upd     = w_exec && w_wr_ok && r_w_strb0;
  assign w_rd_data = w_ar_comp ? {r_busy[w_ar_i], (DATA_WIDTH-STATE_WIDTH-1)'(0), r_state[w_ar_i]} :
                     w_ar_map  ? DATA_WIDTH'(r_busy) : '0;
  assign w_unused  = ^{w_aw_off[1:0], w_ar_off[1:0], w_data[DATA_WIDTH-1:STATE_WIDTH], w_strb[3:1]};
  assign aw_ready  = !r_aw_held && !b_valid;
  assign w_ready   = !r_w_held && !b_valid;
  assign ar_ready  = !r_valid;
  assign pwr_req_o = r_busy;
  for (genvar g = 0; g < NO_COMPS; g++) begin : g_out
    assign pwr_state_o[g*STATE_WIDTH +: STATE_WIDTH] = r_state[g];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      b_valid   <= 1'b0;
      b_resp    <= 2'b00;
      r_valid   <= 1'b0;
      r_resp    <= 2'b00;
      r_data    <= '0;
      r_busy    <= '0;
      for (int i = 0; i < NO_COMPS; i++) r_state[i] <= RST_STATE;
    end else begin
      if (aw_valid && aw_ready) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= aw_addr;
      end
      if (w_valid && w_ready) begin
        r_w_held  <= 1'b1;
        r_w_state <= w_data[STATE_WIDTH-1:0];
        r_w_strb0 <= w_strb[0];
      end
      if (b_valid && b_ready) begin
        b_valid   <= 1'b0;
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
      if (w_exec) begin
        b_valid <= 1'b1;
        b_resp  <= w_wr_ok ? 2'b00 : 2'b10;
      end
      if (w_upd) r_state[w_aw_i] <= r_w_state;
      r_busy <= (r_busy & ~pwr_ack_i) | (w_upd ? NO_COMPS'(1) << w_aw_i : '0);
      if (ar_valid && ar_ready) begin
        r_valid <= 1'b1;
        r_data  <= w_rd_data;
        r_resp  <= (w_ar_comp || w_ar_map) ? 2'b00 : 2'b10;
      end else if (r_valid && r_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_banzai_pwr_cfg_responder.sv
// tb_banzai_pwr_cfg_responder: vector table, corner-case sequences and random traffic vs. a register-map model
module tb_banzai_pwr_cfg_responder;
  localparam int          NC     = 8;
  localparam int          SW     = 4;
  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [3:0]  RST_ST = 4'h1;

  logic          clk = 1'b0, rst = 1'b1;
  logic [31:0]   aw_addr = '0, w_data = '0, ar_addr = '0, r_data;
  logic [3:0]    w_strb = '0;
  logic          aw_valid = 1'b0, w_valid = 1'b0, b_ready = 1'b0, ar_valid = 1'b0, r_ready = 1'b0;
  logic          aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic [1:0]    b_resp, r_resp;
  logic [NC*SW-1:0] pwr_state_o;
  logic [NC-1:0] pwr_req_o, pwr_ack_i = '0;

  always #5 clk = ~clk;

  banzai_pwr_cfg_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NO_COMPS(NC), .STATE_WIDTH(SW),
    .BASE_ADDR(BASE), .RST_STATE(RST_ST)
  ) dut (
    .clk(clk), .rst(rst),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .pwr_state_o(pwr_state_o), .pwr_req_o(pwr_req_o), .pwr_ack_i(pwr_ack_i)
  );

  int n_checks = 0, n_errors = 0;
  logic [SW-1:0] m_state [NC];
  bit            m_busy  [NC];

  typedef struct {
    int          op;
    int          idx;
    logic [31:0] data;
    logic [3:0]  strb;
    int          gap;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NC; i++) begin
      m_state[i] = RST_ST;
      m_busy[i]  = 1'b0;
    end
  endfunction

  function automatic logic [1:0] m_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    if (idx < 0 || idx >= NC || m_busy[idx]) return 2'b10;
    if (s[0]) begin
      m_state[idx] = d[SW-1:0];
      m_busy[idx]  = 1'b1;
    end
    return 2'b00;
  endfunction

  function automatic void m_read(input int idx, output logic [31:0] d, output logic [1:0] r);
    d = '0;
    r = 2'b00;
    if (idx >= 0 && idx < NC) d = {m_busy[idx], 27'b0, m_state[idx]};
    else if (idx == NC) for (int i = 0; i < NC; i++) d[i] = m_busy[i];
    else r = 2'b10;
  endfunction

  function automatic logic [31:0] addr_of(input int idx);
    return BASE + 32'(idx * 4);
  endfunction

  task automatic chk_outs();
    logic [NC-1:0] eb;
    for (int i = 0; i < NC; i++) begin
      eb[i] = m_busy[i];
      chk($sformatf("state%0d", i), 32'(pwr_state_o[i*SW +: SW]), 32'(m_state[i]));
    end
    chk("req", 32'(pwr_req_o), 32'(eb));
  endtask

  task automatic chk_idle();
    chk("aw_ready", 32'(aw_ready), 1);
    chk("w_ready", 32'(w_ready), 1);
    chk("ar_ready", 32'(ar_ready), 1);
    chk("b_valid", 32'(b_valid), 0);
    chk("r_valid", 32'(r_valid), 0);
  endtask

  // all tasks start and end just after a falling edge
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int gap, output logic [1:0] resp);
    int  lat;
    bit  haw, hw, wd;
    wd = 1'b0;
    aw_addr = a; aw_valid = 1'b1; w_data = d; w_strb = s;
    for (int n = 0; n < 50 && (aw_valid || !wd); n++) begin
      if (n == gap) w_valid = 1'b1;
      haw = aw_valid && aw_ready;
      hw  = w_valid && w_ready;
      @(negedge clk);
      if (haw) aw_valid = 1'b0;
      if (hw) begin
        w_valid = 1'b0;
        wd = 1'b1;
      end
    end
    aw_valid = 1'b0; w_valid = 1'b0;
    b_ready = 1'b1;
    lat = 0;
    while (!b_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b_lat", lat, 1);
    resp = b_resp;
    @(negedge clk);
    b_ready = 1'b0;
    chk("b_drop", 32'(b_valid), 0);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    ar_addr = a; ar_valid = 1'b1; r_ready = 1'b1;
    chk("ar_ready", 32'(ar_ready), 1);
    @(negedge clk);
    ar_valid = 1'b0;
    chk("r_lat", 32'(r_valid), 1);
    d = r_data;
    resp = r_resp;
    @(negedge clk);
    r_ready = 1'b0;
    chk("r_drop", 32'(r_valid), 0);
  endtask

  task automatic do_ack(input int idx);
    pwr_ack_i[idx] = 1'b1;
    @(negedge clk);
    pwr_ack_i = '0;
    m_busy[idx] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [1:0]  r, er;
    logic [31:0] d, ed;
    // op: 0 write, 1 read, 2 ack
    tbl[0]  = '{0, 2,    32'h5,         4'hF, 2, 2'b00, 32'h0};
    tbl[1]  = '{1, 2,    32'h0,         4'h0, 0, 2'b00, 32'h8000_0005};
    tbl[2]  = '{1, NC,   32'h0,         4'h0, 0, 2'b00, 32'h0000_0004};
    tbl[3]  = '{0, 2,    32'h9,         4'hF, 0, 2'b10, 32'h0};
    tbl[4]  = '{1, 2,    32'h0,         4'h0, 0, 2'b00, 32'h8000_0005};
    tbl[5]  = '{2, 2,    32'h0,         4'h0, 0, 2'b00, 32'h0};
    tbl[6]  = '{1, 2,    32'h0,         4'h0, 0, 2'b00, 32'h0000_0005};
    tbl[7]  = '{0, 2,    32'h3,         4'hF, 1, 2'b00, 32'h0};
    tbl[8]  = '{1, 2,    32'h0,         4'h0, 0, 2'b00, 32'h8000_0003};
    tbl[9]  = '{0, NC+1, 32'h7,         4'hF, 0, 2'b10, 32'h0};
    tbl[10] = '{1, NC+1, 32'h0,         4'h0, 0, 2'b10, 32'h0};
    tbl[11] = '{0, NC,   32'hFF,        4'hF, 0, 2'b10, 32'h0};
    tbl[12] = '{0, 0,    32'h7,         4'hE, 0, 2'b00, 32'h0};
    tbl[13] = '{1, 0,    32'h0,         4'h0, 0, 2'b00, 32'h0000_0001};
    tbl[14] = '{2, 2,    32'h0,         4'h0, 0, 2'b00, 32'h0};
    tbl[15] = '{1, NC,   32'h0,         4'h0, 0, 2'b00, 32'h0};
    tbl[16] = '{1, NC-1, 32'h0,         4'h0, 0, 2'b00, 32'h0000_0001};
    tbl[17] = '{0, NC-1, 32'hFFFF_FFFA, 4'hF, 1, 2'b00, 32'h0};
    tbl[18] = '{1, NC-1, 32'h0,         4'h0, 0, 2'b00, 32'h8000_000A};
    tbl[19] = '{2, 0,    32'h0,         4'h0, 0, 2'b00, 32'h0};

    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_idle();
    chk_outs();
    chk("rst_r_data", r_data, 0);
    chk("rst_b_resp", 32'(b_resp), 0);
    chk("rst_r_resp", 32'(r_resp), 0);

    for (int v = 0; v < 20; v++) begin
      if (tbl[v].op == 0) begin
        do_write(addr_of(tbl[v].idx), tbl[v].data, tbl[v].strb, tbl[v].gap, r);
        er = m_write(tbl[v].idx, tbl[v].data, tbl[v].strb);
        chk($sformatf("vec%0d_bresp", v), 32'(r), 32'(tbl[v].resp));
      end else if (tbl[v].op == 1) begin
        do_read(addr_of(tbl[v].idx), d, r);
        chk($sformatf("vec%0d_rdata", v), d, tbl[v].rdata);
        chk($sformatf("vec%0d_rresp", v), 32'(r), 32'(tbl[v].resp));
      end else begin
        do_ack(tbl[v].idx);
      end
      chk_outs();
    end

    // write execute and ack land on the same edge: ack wins, write refused
    do_write(addr_of(4), 32'h9, 4'hF, 0, r);
    er = m_write(4, 32'h9, 4'hF);
    chk("c4_first", 32'(r), 32'(er));
    aw_addr = addr_of(4); w_data = 32'h2; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b1;
    @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0; pwr_ack_i[4] = 1'b1;
    @(negedge clk);
    pwr_ack_i = '0;
    m_busy[4] = 1'b0;
    chk("race_bvalid", 32'(b_valid), 1);
    chk("race_bresp", 32'(b_resp), 32'(2'b10));
    chk_outs();
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;

    // back-pressure on B and R, with a read executing on the write's execute edge
    aw_addr = addr_of(5); w_data = 32'h6; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b1;
    @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0;
    ar_addr = addr_of(5); ar_valid = 1'b1;
    @(negedge clk);
    ar_valid = 1'b0;
    m_read(5, ed, er);
    void'(m_write(5, 32'h6, 4'hF));
    for (int c = 0; c < 6; c++) begin
      chk("stall_bvalid", 32'(b_valid), 1);
      chk("stall_bresp", 32'(b_resp), 0);
      chk("stall_rvalid", 32'(r_valid), 1);
      chk("stall_rdata", r_data, ed);
      chk("stall_rresp", 32'(r_resp), 32'(er));
      chk("stall_readys", {29'b0, aw_ready, w_ready, ar_ready}, 0);
      @(negedge clk);
    end
    chk_outs();
    b_ready = 1'b1; r_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0; r_ready = 1'b0;
    chk_idle();
    do_ack(5);
    chk_outs();

    // reset while AW is held and W has not arrived drops the transaction
    aw_addr = addr_of(3); w_data = 32'h7; w_strb = 4'hF; aw_valid = 1'b1;
    @(negedge clk);
    aw_valid = 1'b0;
    chk("held_aw_ready", 32'(aw_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    repeat (3) begin
      chk("rst_no_b", 32'(b_valid), 0);
      @(negedge clk);
    end
    chk_idle();
    chk_outs();
    do_write(addr_of(3), 32'h7, 4'hF, 0, r);
    chk("post_rst_write", 32'(r), 32'(m_write(3, 32'h7, 4'hF)));
    chk_outs();

    for (int k = 0; k < 200; k++) begin
      int sel, idx;
      logic [31:0] rd;
      logic [3:0]  rs;
      sel = $urandom_range(0, 9);
      idx = $urandom_range(0, NC + 2) - 1;
      if (sel < 4) begin
        rd = $urandom;
        rs = 4'($urandom_range(0, 15));
        do_write(addr_of(idx), rd, rs, $urandom_range(0, 2), r);
        chk($sformatf("rnd%0d_bresp", k), 32'(r), 32'(m_write(idx, rd, rs)));
      end else if (sel < 7) begin
        m_read(idx, ed, er);
        do_read(addr_of(idx), d, r);
        chk($sformatf("rnd%0d_rdata", k), d, ed);
        chk($sformatf("rnd%0d_rresp", k), 32'(r), 32'(er));
      end else begin
        do_ack($urandom_range(0, NC - 1));
      end
      chk_outs();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
